// File: rtl/cm0_dap_cdc_pkg.sv
// ---------------------------------------------------------------------------
// cm0_dap_cdc_pkg : shared types and constants for the DAP CDC handshake blocks
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package cm0_dap_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOAD   = 2'd3
  } hs_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic int clamp_sync_stages(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cm0_dap_cdc_sync.sv
// ---------------------------------------------------------------------------
// cm0_dap_cdc_sync : reset-to-0 flop-chain synchroniser (swap for library cell)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module cm0_dap_cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic REGCLK,
  input  logic RARREGRESETn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
    if (!RARREGRESETn) sync_q <= '0;
    else               sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cm0_dap_cdc_hs_send.sv
// ---------------------------------------------------------------------------
// cm0_dap_cdc_hs_send : toggle-handshake multi-bit launch register
// Optional holding buffer: define CM0_DAP_CDC_HS_SEND_BUF_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module cm0_dap_cdc_hs_send
  import cm0_dap_cdc_pkg::*;
#(
  parameter int PRESENT     = 1,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             REGCLK,
  input  logic             RARREGRESETn,
  input  logic             SE,
  input  logic             SVALID,
  output logic             SREADY,
  input  logic [WIDTH-1:0] SDATA,
  output logic             REQ,
  output logic [WIDTH-1:0] DATA,
  input  logic             ACK,
  output logic             BUSY
);

  localparam int SYNC_N = clamp_sync_stages(SYNC_STAGES);

  generate
    if (PRESENT != 0) begin : g_present
      hs_state_e        state;
      logic             req_q;
      logic [WIDTH-1:0] data_q;
      logic             ack_sync;
      logic             done;
      logic             accept;
      logic             unused_se;

      assign unused_se = SE;

      cm0_dap_cdc_sync #(.STAGES(SYNC_N)) u_ack_sync (
        .REGCLK       (REGCLK),
        .RARREGRESETn (RARREGRESETn),
        .d            (ACK),
        .q            (ack_sync)
      );

      assign done   = (ack_sync == req_q);
      assign accept = SVALID & SREADY;
      assign REQ    = req_q;
      assign DATA   = data_q;

`ifdef CM0_DAP_CDC_HS_SEND_BUF_EN
      logic [WIDTH-1:0] buf_q;
      logic             buf_full;

      always_comb begin
        case (state)
          ST_IDLE:             SREADY = done;
          ST_LAUNCH, ST_WAIT:  SREADY = ~buf_full;
          default:             SREADY = 1'b0;
        endcase
      end

      assign BUSY = (state != ST_IDLE) | buf_full;

      always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
        if (!RARREGRESETn) begin
          state    <= ST_IDLE;
          req_q    <= 1'b0;
          data_q   <= '0;
          buf_q    <= '0;
          buf_full <= 1'b0;
        end else begin
          if (accept && (state != ST_IDLE)) begin
            buf_q    <= SDATA;
            buf_full <= 1'b1;
          end
          case (state)
            ST_IDLE: if (accept) begin
              data_q <= SDATA;
              state  <= ST_LAUNCH;
            end
            ST_LAUNCH: begin
              req_q <= ~req_q;
              state <= ST_WAIT;
            end
            // A word written in the completion cycle must still go through LOAD
            ST_WAIT: if (done) state <= (buf_full | accept) ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
              data_q   <= buf_q;
              buf_full <= 1'b0;
              state    <= ST_LAUNCH;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
`else
      assign SREADY = (state == ST_IDLE) & done;
      assign BUSY   = (state != ST_IDLE);

      always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
        if (!RARREGRESETn) begin
          state  <= ST_IDLE;
          req_q  <= 1'b0;
          data_q <= '0;
        end else begin
          case (state)
            ST_IDLE: if (accept) begin
              data_q <= SDATA;
              state  <= ST_LAUNCH;
            end
            ST_LAUNCH: begin
              req_q <= ~req_q;
              state <= ST_WAIT;
            end
            ST_WAIT: if (done) state <= ST_IDLE;
            default: state <= ST_IDLE;
          endcase
        end
      end
`endif
    end else begin : g_absent
      logic unused_inputs;
      assign unused_inputs = ^{REGCLK, RARREGRESETn, SE, SVALID, SDATA, ACK};
      assign SREADY = 1'b1;
      assign REQ    = 1'b0;
      assign DATA   = '0;
      assign BUSY   = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cm0_dap_cdc_hs_send.sv
// ---------------------------------------------------------------------------
// tb_cm0_dap_cdc_hs_send : directed bench for cm0_dap_cdc_hs_send
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module tb_cm0_dap_cdc_hs_send;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         svalid;
  logic [W-1:0] sdata;
  logic         se;

  logic         sready_a, req_a, busy_a, ack_a;
  logic [W-1:0] data_a;
  logic         sready_b, req_b, busy_b, ack_b;
  logic [W-1:0] data_b;
  logic         sready_n, req_n, busy_n, ack_n;
  logic [W-1:0] data_n;

  logic [2:0]   pipe_a, pipe_b;
  logic         ack_ovr_en, ack_ovr;

  int n_pass  = 0;
  int n_total = 0;

  // Receiver models: echo REQ back as ACK three cycles later
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_a <= '0; else pipe_a <= {pipe_a[1:0], req_a};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_b <= '0; else pipe_b <= {pipe_b[1:0], req_b};

  assign ack_a = ack_ovr_en ? ack_ovr : pipe_a[2];
  assign ack_b = pipe_b[2];
  assign ack_n = 1'b0;

  cm0_dap_cdc_hs_send #(.PRESENT(1), .WIDTH(W), .SYNC_STAGES(2)) dut_a (
    .REGCLK(clk), .RARREGRESETn(rst_n), .SE(se), .SVALID(svalid), .SREADY(sready_a),
    .SDATA(sdata), .REQ(req_a), .DATA(data_a), .ACK(ack_a), .BUSY(busy_a));

  cm0_dap_cdc_hs_send #(.PRESENT(1), .WIDTH(W), .SYNC_STAGES(4)) dut_b (
    .REGCLK(clk), .RARREGRESETn(rst_n), .SE(se), .SVALID(svalid), .SREADY(sready_b),
    .SDATA(sdata), .REQ(req_b), .DATA(data_b), .ACK(ack_b), .BUSY(busy_b));

  cm0_dap_cdc_hs_send #(.PRESENT(0), .WIDTH(W), .SYNC_STAGES(2)) dut_n (
    .REGCLK(clk), .RARREGRESETn(rst_n), .SE(se), .SVALID(svalid), .SREADY(sready_n),
    .SDATA(sdata), .REQ(req_n), .DATA(data_n), .ACK(ack_n), .BUSY(busy_n));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    svalid     = 1'b0;
    sdata      = '0;
    ack_ovr_en = 1'b0;
    ack_ovr    = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    svalid = 1'b1; sdata = 32'hFFFF_FFFF; se = 1'b0;
    ack_ovr_en = 1'b0; ack_ovr = 1'b0;
    rst_n = 1'b0;
    #13;
    n_total++;
    if ({req_a, busy_a, sready_a, data_a} !== {1'b0, 1'b0, 1'b1, 32'h0})
      $display("FAIL reset_a: req=%b busy=%b sready=%b data=%h, want 0 0 1 00000000",
               req_a, busy_a, sready_a, data_a);
    else n_pass++;
    n_total++;
    if ({req_b, busy_b, sready_b, data_b} !== {1'b0, 1'b0, 1'b1, 32'h0})
      $display("FAIL reset_b: req=%b busy=%b sready=%b data=%h, want 0 0 1 00000000",
               req_b, busy_b, sready_b, data_b);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single;
    logic exp_req, exp_busy, exp_rdy;
    do_reset();
    n_total++;
    if (sready_a !== 1'b1) $display("FAIL single_idle_ready: sready=%b want 1", sready_a);
    else n_pass++;
    svalid = 1'b1; sdata = 32'hDEAD_BEEF;
    tick();
    svalid = 1'b0; sdata = '0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      exp_req  = (k >= 1);
      exp_busy = (k <= 6);
`ifdef CM0_DAP_CDC_HS_SEND_BUF_EN
      exp_rdy  = 1'b1;
`else
      exp_rdy  = (k >= 7);
`endif
      n_total++;
      if ({req_a, busy_a, sready_a, data_a} !== {exp_req, exp_busy, exp_rdy, 32'hDEAD_BEEF})
        $display("FAIL single_k%0d: req=%b busy=%b sready=%b data=%h, want %b %b %b deadbeef",
                 k, req_a, busy_a, sready_a, data_a, exp_req, exp_busy, exp_rdy);
      else n_pass++;
    end
  endtask

  task automatic test_stability;
    do_reset();
    svalid = 1'b1; sdata = 32'h1234_5678;
    tick();
    for (int k = 1; k <= 7; k++) begin
`ifdef CM0_DAP_CDC_HS_SEND_BUF_EN
      svalid = 1'b0;
`else
      svalid = 1'($urandom);
`endif
      sdata = $urandom;
      tick();
      n_total++;
      if (data_a !== 32'h1234_5678 || req_a !== 1'b1)
        $display("FAIL stable_k%0d: data=%h req=%b, want 12345678 1", k, data_a, req_a);
      else n_pass++;
    end
    svalid = 1'b0;
    n_total++;
    if (busy_a !== 1'b0) $display("FAIL stable_done: busy=%b want 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_sync_depth;
    int done_a, done_b;
    done_a = -1; done_b = -1;
    do_reset();
    svalid = 1'b1; sdata = 32'hCAFE_F00D;
    tick();
    svalid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (done_a < 0 && busy_a === 1'b0) done_a = k;
      if (done_b < 0 && busy_b === 1'b0) done_b = k;
    end
    n_total++;
    if (done_a !== 7) $display("FAIL depth2_done: cycle=%0d want 7", done_a);
    else n_pass++;
    n_total++;
    if (done_b !== 9) $display("FAIL depth4_done: cycle=%0d want 9", done_b);
    else n_pass++;
    n_total++;
    if ({sready_b, req_b, data_b} !== {1'b1, 1'b1, 32'hCAFE_F00D})
      $display("FAIL depth4_end: sready=%b req=%b data=%h, want 1 1 cafef00d",
               sready_b, req_b, data_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    svalid = 1'b1; sdata = 32'hA5A5_A5A5;
    tick();
    svalid = 1'b0;
    repeat (5) tick();
    n_total++;
    if ({req_a, busy_a} !== 2'b11) $display("FAIL mid_pre: req=%b busy=%b want 1 1", req_a, busy_a);
    else n_pass++;
    ack_ovr_en = 1'b1; ack_ovr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_a, busy_a, data_a} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL mid_async: req=%b busy=%b data=%h want 0 0 00000000", req_a, busy_a, data_a);
    else n_pass++;
    #1 rst_n = 1'b1;
    tick();
    tick();
    sdata = 32'h0000_0055; svalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if ({sready_a, req_a, busy_a} !== 3'b000)
        $display("FAIL mid_hold_k%0d: sready=%b req=%b busy=%b want 0 0 0", k, sready_a, req_a, busy_a);
      else n_pass++;
      tick();
    end
    svalid = 1'b0; ack_ovr = 1'b0;
    tick();
    n_total++;
    if (sready_a !== 1'b0) $display("FAIL mid_ack_prop1: sready=%b want 0", sready_a);
    else n_pass++;
    tick();
    n_total++;
    if (sready_a !== 1'b1) $display("FAIL mid_ack_prop2: sready=%b want 1", sready_a);
    else n_pass++;
    ack_ovr_en = 1'b0;
  endtask

  task automatic test_present0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      svalid = 1'($urandom); sdata = $urandom;
      tick();
      n_total++;
      if ({sready_n, req_n, busy_n, data_n} !== {1'b1, 1'b0, 1'b0, 32'h0})
        $display("FAIL absent_k%0d: sready=%b req=%b busy=%b data=%h want 1 0 0 00000000",
                 k, sready_n, req_n, busy_n, data_n);
      else n_pass++;
    end
    svalid = 1'b0;
  endtask

`ifdef CM0_DAP_CDC_HS_SEND_BUF_EN
  logic [W-1:0] seen [0:3];
  int           n_tog;
  logic         prev_req;

  task automatic buf_tick;
    tick();
    if (req_a !== prev_req) begin
      if (n_tog < 4) seen[n_tog] = data_a;
      n_tog++;
      prev_req = req_a;
    end
  endtask

  task automatic test_back_to_back;
    int acc3;
    int stall_bad;
    acc3 = -1; stall_bad = 0; n_tog = 0;
    do_reset();
    prev_req = req_a;
    svalid = 1'b1; sdata = 32'h1;
    buf_tick();
    svalid = 1'b0;
    buf_tick();
    n_total++;
    if (sready_a !== 1'b1) $display("FAIL buf_wait_ready: sready=%b want 1", sready_a);
    else n_pass++;
    svalid = 1'b1; sdata = 32'h2;
    buf_tick();
    sdata = 32'h3;
    for (int k = 2; k <= 26; k++) begin
      if (k > 2) buf_tick();
      if (k <= 7 && sready_a !== 1'b0) stall_bad++;
      if (svalid && sready_a === 1'b1) begin
        acc3 = k + 1;
        buf_tick();
        svalid = 1'b0;
        k++;
      end
    end
    n_total++;
    if (stall_bad !== 0) $display("FAIL buf_stall: ready_cycles=%0d want 0", stall_bad);
    else n_pass++;
    n_total++;
    if (acc3 !== 9) $display("FAIL buf_acc3: cycle=%0d want 9", acc3);
    else n_pass++;
    n_total++;
    if (n_tog !== 3) $display("FAIL buf_toggles: count=%0d want 3", n_tog);
    else n_pass++;
    n_total++;
    if ({seen[0], seen[1], seen[2]} !== {32'h1, 32'h2, 32'h3})
      $display("FAIL buf_order: %h %h %h want 1 2 3", seen[0], seen[1], seen[2]);
    else n_pass++;
    n_total++;
    if (busy_a !== 1'b0) $display("FAIL buf_end_busy: busy=%b want 0", busy_a);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stability();
    test_sync_depth();
    test_reset_mid();
    test_present0();
`ifdef CM0_DAP_CDC_HS_SEND_BUF_EN
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
